// File: rtl/arbitro_memoria_datos_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states,
// byte-lane constants and the alignment rule.
package arbitro_memoria_datos_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ACCESS    = 2'b01,
        ST_READ_WAIT = 2'b10,
        ST_RESP      = 2'b11
    } state_e;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [NUM_LANES-1:0] WEA_NONE    = 4'b0000;
    localparam logic [NUM_LANES-1:0] WEA_BYTE0   = 4'b0001;
    localparam logic [NUM_LANES-1:0] WEA_HALF_LO = 4'b0011;
    localparam logic [NUM_LANES-1:0] WEA_HALF_HI = 4'b1100;
    localparam logic [NUM_LANES-1:0] WEA_WORD    = 4'b1111;

    localparam logic PORT_P0 = 1'b0;
    localparam logic PORT_P1 = 1'b1;

    // A request that fails this never reaches the memory.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = |off;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/arbitro_memoria_datos_if.sv
// One requester port of the arbiter: request fields in, completion out.
interface arbitro_memoria_datos_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();

    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W+1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output ack, err, rdata
    );

endinterface

// File: rtl/arbitro_memoria_datos_alineador_carga.sv
// Load aligner: picks the addressed byte/half/word out of a memory word and
// zero- or sign-extends it to the full data width.
module alineador_carga
    import arbitro_memoria_datos_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] douta_i,
    input  size_e             size_i,
    input  logic              sext_i,
    input  logic [1:0]        off_i,
    output logic [DATA_W-1:0] data_o
);

    logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
    logic [LANE_W-1:0]                byte_sel;
    logic [2*LANE_W-1:0]              half_sel;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lanes[gi] = douta_i[gi*LANE_W +: LANE_W];
        end
    endgenerate

    always_comb begin
        byte_sel = lanes[off_i];
        half_sel = off_i[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
        case (size_i)
            SIZE_BYTE: data_o = {{(DATA_W-LANE_W){sext_i & byte_sel[LANE_W-1]}}, byte_sel};
            SIZE_HALF: data_o = {{(DATA_W-2*LANE_W){sext_i & half_sel[2*LANE_W-1]}}, half_sel};
            default:   data_o = douta_i;
        endcase
    end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Round-robin arbiter giving the CPU MEM stage (p0) and the debug unit (p1)
// shared access to memoria_de_datos, one transaction at a time.
module arbitro_memoria_datos
    import arbitro_memoria_datos_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                  clka,
    input  logic                  reset,
    arbitro_memoria_datos_if.slave p0,
    arbitro_memoria_datos_if.slave p1,
    output logic                  mem_ena,
    output logic [NUM_LANES-1:0]  mem_wea,
    output logic [ADDR_W-1:0]     mem_addra,
    output logic [DATA_W-1:0]     mem_dina,
    input  logic [DATA_W-1:0]     mem_douta
);

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              any_req;
    logic              gnt_port;
    logic              gnt_we;
    size_e             gnt_size;
    logic              gnt_sext;
    logic [ADDR_W+1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

    logic [NUM_LANES-1:0] st_wea;
    logic [DATA_W-1:0]    st_din;
    logic [DATA_W-1:0]    load_data;
    logic                 resp0, resp1;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        any_req   = p0.req | p1.req;
        gnt_port  = (p0.req && p1.req) ? ~last_q : p1.req;
        gnt_we    = gnt_port ? p1.we    : p0.we;
        gnt_size  = size_e'(gnt_port ? p1.size : p0.size);
        gnt_sext  = gnt_port ? p1.sext  : p0.sext;
        gnt_addr  = gnt_port ? p1.addr  : p0.addr;
        gnt_wdata = gnt_port ? p1.wdata : p0.wdata;
    end

    always_comb begin
        case (size_q)
            SIZE_BYTE: st_wea = WEA_BYTE0 << addr_q[1:0];
            SIZE_HALF: st_wea = addr_q[1] ? WEA_HALF_HI : WEA_HALF_LO;
            SIZE_WORD: st_wea = WEA_WORD;
            default:   st_wea = WEA_NONE;
        endcase
    end

    // Store data is replicated so that whichever lanes are enabled see it.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_st_lane
            assign st_din[gi*LANE_W +: LANE_W] =
                (size_q == SIZE_BYTE) ? wdata_q[LANE_W-1:0] :
                (size_q == SIZE_HALF) ? wdata_q[(gi%2)*LANE_W +: LANE_W] :
                                        wdata_q[gi*LANE_W +: LANE_W];
        end
    endgenerate

    alineador_carga #(
        .DATA_W (DATA_W)
    ) u_alineador_carga (
        .douta_i (mem_douta),
        .size_i  (size_q),
        .sext_i  (sext_q),
        .off_i   (addr_q[1:0]),
        .data_o  (load_data)
    );

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        last_d   = last_q;
        we_d     = we_q;
        size_d   = size_q;
        sext_d   = sext_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    port_d  = gnt_port;
                    last_d  = gnt_port;
                    we_d    = gnt_we;
                    size_d  = gnt_size;
                    sext_d  = gnt_sext;
                    addr_d  = gnt_addr;
                    wdata_d = gnt_wdata;
                    err_d   = is_misaligned(gnt_size, gnt_addr[1:0]);
                    state_d = err_d ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = we_q ? ST_RESP : ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                if (port_q == PORT_P1) begin
                    rdata1_d = load_data;
                end else begin
                    rdata0_d = load_data;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            port_q   <= PORT_P0;
            last_q   <= PORT_P1;
            we_q     <= 1'b0;
            size_q   <= SIZE_BYTE;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            last_q   <= last_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Memory strobes exist only during ACCESS; everything else idles at zero.
    always_comb begin
        mem_ena   = 1'b0;
        mem_wea   = WEA_NONE;
        mem_addra = '0;
        mem_dina  = '0;
        if (state_q == ST_ACCESS) begin
            mem_ena   = 1'b1;
            mem_addra = addr_q[ADDR_W+1:2];
            if (we_q) begin
                mem_wea  = st_wea;
                mem_dina = st_din;
            end
        end
    end

    assign resp0 = (state_q == ST_RESP) && (port_q == PORT_P0);
    assign resp1 = (state_q == ST_RESP) && (port_q == PORT_P1);

    assign p0.ack   = resp0;
    assign p0.err   = resp0 & err_q;
    assign p0.rdata = rdata0_q;
    assign p1.ack   = resp1;
    assign p1.err   = resp1 & err_q;
    assign p1.rdata = rdata1_q;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: directed cases plus randomized traffic
// against a transaction-level model of the arbiter and a byte-array memory.
module tb_arbitro_memoria_datos;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 32;
    localparam int MODEL_BYTES = 256;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [13:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    logic init_phase;
    logic              mem_ena;
    logic [3:0]        mem_wea;
    logic [ADDR_W-1:0] mem_addra;
    logic [31:0]       mem_dina;
    logic [31:0]       mem_douta;
    logic [31:0]       ram [0:(1<<ADDR_W)-1];

    arbitro_memoria_datos_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0_if ();
    arbitro_memoria_datos_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1_if ();

    arbitro_memoria_datos #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clka      (clk),
        .reset     (reset),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_ena   (mem_ena),
        .mem_wea   (mem_wea),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_douta (mem_douta)
    );

    always #5 clk = ~clk;

    // memoria_de_datos stand-in: registered read-first block RAM
    always @(posedge clk) begin
        if (init_phase) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 32'h0;
            mem_douta <= 32'h0;
        end else if (mem_ena) begin
            for (int i = 0; i < 4; i++)
                if (mem_wea[i]) ram[mem_addra][8*i +: 8] <= mem_dina[8*i +: 8];
            mem_douta <= ram[mem_addra];
        end
    end

    // ---------------- reference model state ----------------
    logic [7:0]  ref_mem [0:MODEL_BYTES-1];
    int          cyc, next_free, ack_at, acc_at;
    logic        last_m;
    logic        pend_port, pend_err, pend_load, pend_we;
    logic [31:0] pend_rdata, pend_wdata;
    logic [3:0]  pend_wea;
    logic [ADDR_W-1:0] pend_addra;
    int          pend_off;
    logic        exp_ack [2];
    logic        exp_err [2];
    logic [31:0] exp_rd  [2];
    logic        exp_ena;

    int          vectors, miscompares;
    logic        ena_seen;
    logic [3:0]  wea_seen;
    logic [ADDR_W-1:0] addra_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    task automatic drive(input int p, input logic r, input txn_t t);
        if (p == 0) begin
            p0_if.req = r; p0_if.we = t.we; p0_if.size = t.size;
            p0_if.sext = t.sext; p0_if.addr = t.addr; p0_if.wdata = t.wdata;
        end else begin
            p1_if.req = r; p1_if.we = t.we; p1_if.size = t.size;
            p1_if.sext = t.sext; p1_if.addr = t.addr; p1_if.wdata = t.wdata;
        end
    endtask

    function automatic txn_t port_txn(input logic p);
        txn_t t;
        if (p) begin
            t.we = p1_if.we; t.size = p1_if.size; t.sext = p1_if.sext;
            t.addr = p1_if.addr; t.wdata = p1_if.wdata;
        end else begin
            t.we = p0_if.we; t.size = p0_if.size; t.sext = p0_if.sext;
            t.addr = p0_if.addr; t.wdata = p0_if.wdata;
        end
        return t;
    endfunction

    // Transaction-level view: a grant happens when the arbiter is free, the
    // outcome is fixed at grant, and the ack appears a fixed latency later.
    task automatic model_edge();
        logic r0, r1, w, bad;
        txn_t t;
        int nb, a;
        logic [31:0] val;
        cyc++;
        if (reset) begin
            ack_at = -1; acc_at = -1; last_m = 1'b1;
            exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
            next_free = cyc + 1;
            exp_ena = 1'b0;
            for (int p = 0; p < 2; p++) begin exp_ack[p] = 1'b0; exp_err[p] = 1'b0; end
            return;
        end
        r0 = p0_if.req; r1 = p1_if.req;
        if (cyc >= next_free && (r0 || r1)) begin
            w = (r0 && r1) ? !last_m : r1;
            last_m = w;
            t = port_txn(w);
            nb = nbytes(t.size);
            a = int'(t.addr);
            bad = (t.size == 2'd3) || ((a % nb) != 0);
            pend_port = w; pend_err = bad; pend_load = !t.we; pend_we = t.we;
            if (bad) ack_at = cyc;
            else if (t.we) ack_at = cyc + 1;
            else ack_at = cyc + 2;
            acc_at = bad ? -1 : cyc;
            next_free = ack_at + 2;
            if (!bad) begin
                pend_addra = ADDR_W'(a >> 2);
                pend_off   = a % 4;
                pend_wea   = 4'(((1 << nb) - 1) << pend_off);
                pend_wdata = t.wdata;
                if (t.we) begin
                    for (int i = 0; i < nb; i++) ref_mem[a + i] = t.wdata[8*i +: 8];
                end else begin
                    val = 32'h0;
                    for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[a + i]) << (8*i));
                    if (t.sext && nb < 4 && val[8*nb-1])
                        val = val | ~((32'h1 << (8*nb)) - 32'h1);
                    pend_rdata = val;
                end
            end
        end
        exp_ena = (acc_at == cyc);
        for (int p = 0; p < 2; p++) begin
            exp_ack[p] = (ack_at == cyc) && (pend_port == p[0]);
            exp_err[p] = exp_ack[p] && pend_err;
            if (exp_ack[p] && pend_load && !pend_err) exp_rd[p] = pend_rdata;
        end
    endtask

    task automatic compare();
        chk("p0_ack",   {31'h0, p0_if.ack}, {31'h0, exp_ack[0]});
        chk("p1_ack",   {31'h0, p1_if.ack}, {31'h0, exp_ack[1]});
        chk("p0_err",   {31'h0, p0_if.err}, {31'h0, exp_err[0]});
        chk("p1_err",   {31'h0, p1_if.err}, {31'h0, exp_err[1]});
        chk("p0_rdata", p0_if.rdata, exp_rd[0]);
        chk("p1_rdata", p1_if.rdata, exp_rd[1]);
        chk("mem_ena",  {31'h0, mem_ena}, {31'h0, exp_ena});
        if (exp_ena) begin
            chk("mem_addra", 32'(mem_addra), 32'(pend_addra));
            if (pend_we) begin
                chk("mem_wea", 32'(mem_wea), 32'(pend_wea));
                for (int i = 0; i < 4; i++)
                    if (pend_wea[i])
                        chk("mem_dina_lane", 32'(mem_dina[8*i +: 8]),
                            32'(pend_wdata[8*(i - pend_off) +: 8]));
            end else begin
                chk("mem_wea_load", 32'(mem_wea), 32'h0);
            end
        end else begin
            chk("mem_wea_idle", 32'(mem_wea), 32'h0);
        end
        if (mem_ena) begin
            ena_seen = 1'b1; wea_seen = mem_wea; addra_seen = mem_addra;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic do_txn(input int p, input txn_t t, output int lat,
                          output logic [31:0] rd, output logic er);
        logic got;
        got = 1'b0; lat = 0; rd = 32'h0; er = 1'b0; ena_seen = 1'b0;
        drive(p, 1'b1, t);
        for (int n = 1; n <= 8 && !got; n++) begin
            tick();
            if ((p == 0) ? p0_if.ack : p1_if.ack) begin
                got = 1'b1; lat = n;
                rd = (p == 0) ? p0_if.rdata : p1_if.rdata;
                er = (p == 0) ? p0_if.err : p1_if.err;
            end
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL txn_timeout: port %0d got no ack, expected one within 8 cycles", p);
        end
        drive(p, 1'b0, t);
        tick();
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int nb;
        t.we    = 1'($urandom % 2);
        t.size  = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
        t.sext  = 1'($urandom % 2);
        t.addr  = 14'($urandom % MODEL_BYTES);
        t.wdata = $urandom;
        nb = nbytes(t.size);
        if ($urandom % 4 != 0) t.addr = t.addr & ~14'(nb - 1);
        return t;
    endfunction

    function automatic txn_t mk(input logic we, input logic [1:0] size, input logic sext,
                                input logic [13:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.size = size; t.sext = sext; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    initial begin
        txn_t t0, t1;
        int lat, nacks;
        logic [31:0] rd;
        logic er;
        int order [4];

        vectors = 0; miscompares = 0; cyc = 0; next_free = 0;
        ack_at = -1; acc_at = -1; last_m = 1'b1; pend_port = 1'b0;
        pend_err = 1'b0; pend_load = 1'b0; pend_we = 1'b0; pend_off = 0;
        pend_rdata = 0; pend_wdata = 0; pend_wea = 0; pend_addra = 0;
        for (int i = 0; i < MODEL_BYTES; i++) ref_mem[i] = 8'h0;
        t0 = mk(1'b0, 2'd0, 1'b0, 14'h0, 32'h0);
        drive(0, 1'b0, t0);
        drive(1, 1'b0, t0);
        reset = 1'b1; init_phase = 1'b1;
        tick(); tick();
        init_phase = 1'b0;

        // reset values
        chk("rst_p0_rdata", p0_if.rdata, 32'h0);
        chk("rst_p1_rdata", p1_if.rdata, 32'h0);
        chk("rst_acks", {30'h0, p1_if.ack, p0_if.ack}, 32'h0);
        chk("rst_mem_ena", {31'h0, mem_ena}, 32'h0);
        chk("rst_mem_wea", 32'(mem_wea), 32'h0);
        chk("rst_mem_addra", 32'(mem_addra), 32'h0);
        chk("rst_mem_dina", mem_dina, 32'h0);
        reset = 1'b0;

        // word store then word load at 0x004
        do_txn(0, mk(1'b1, 2'd2, 1'b0, 14'h004, 32'hDEADBEEF), lat, rd, er);
        chk("st_word_lat", 32'(lat), 32'd2);
        chk("st_word_wea", 32'(wea_seen), 32'hF);
        chk("st_word_addra", 32'(addra_seen), 32'h1);
        do_txn(0, mk(1'b0, 2'd2, 1'b1, 14'h004, 32'h0), lat, rd, er);
        chk("ld_word_lat", 32'(lat), 32'd3);
        chk("ld_word_rdata", rd, 32'hDEADBEEF);

        // byte store 0x80 at 0x007, signed and unsigned reads
        do_txn(0, mk(1'b1, 2'd0, 1'b0, 14'h007, 32'h00000080), lat, rd, er);
        chk("st_byte_wea", 32'(wea_seen), 32'h8);
        do_txn(0, mk(1'b0, 2'd0, 1'b1, 14'h007, 32'h0), lat, rd, er);
        chk("ld_byte_signed", rd, 32'hFFFFFF80);
        do_txn(0, mk(1'b0, 2'd0, 1'b0, 14'h007, 32'h0), lat, rd, er);
        chk("ld_byte_unsigned", rd, 32'h00000080);

        // misaligned half and illegal size from p1
        do_txn(1, mk(1'b0, 2'd1, 1'b0, 14'h003, 32'h0), lat, rd, er);
        chk("err_half_lat", 32'(lat), 32'd1);
        chk("err_half_err", {31'h0, er}, 32'h1);
        chk("err_half_noena", {31'h0, ena_seen}, 32'h0);
        do_txn(1, mk(1'b0, 2'd3, 1'b0, 14'h000, 32'h0), lat, rd, er);
        chk("err_size3_lat", 32'(lat), 32'd1);
        chk("err_size3_err", {31'h0, er}, 32'h1);
        chk("err_size3_noena", {31'h0, ena_seen}, 32'h0);

        // both ports held: grants alternate starting with p0
        t0 = mk(1'b0, 2'd2, 1'b0, 14'h004, 32'h0);
        t1 = mk(1'b0, 2'd0, 1'b0, 14'h005, 32'h0);
        drive(0, 1'b1, t0); drive(1, 1'b1, t1);
        nacks = 0;
        for (int n = 0; n < 40 && nacks < 4; n++) begin
            tick();
            if (p0_if.ack) begin order[nacks] = 0; nacks++; end
            else if (p1_if.ack) begin order[nacks] = 1; nacks++; end
        end
        drive(0, 1'b0, t0); drive(1, 1'b0, t1);
        tick(); tick();
        chk("rr_ack_count", 32'(nacks), 32'd4);
        chk("rr_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]}, 32'h00010001);
        chk("rr_p0_rdata", p0_if.rdata, 32'h80ADBEEF);
        chk("rr_p1_rdata", p1_if.rdata, 32'h000000BE);

        // reset during READ_WAIT aborts the load
        drive(0, 1'b1, mk(1'b0, 2'd2, 1'b0, 14'h004, 32'h0));
        tick(); tick();
        reset = 1'b1;
        drive(0, 1'b0, t0);
        tick();
        chk("abort_ack", {31'h0, p0_if.ack}, 32'h0);
        chk("abort_rdata", p0_if.rdata, 32'h0);
        chk("abort_ena", {31'h0, mem_ena}, 32'h0);
        reset = 1'b0;
        tick();
        chk("abort_noack", {31'h0, p0_if.ack}, 32'h0);
        do_txn(0, mk(1'b0, 2'd2, 1'b0, 14'h004, 32'h0), lat, rd, er);
        chk("after_reset_lat", 32'(lat), 32'd3);
        chk("after_reset_rdata", rd, 32'h80ADBEEF);

        // randomized traffic with occasional resets
        for (int it = 0; it < 3000; it++) begin
            if (it == 1000 || it == 2001) begin
                reset = 1'b1;
                drive(0, 1'b0, t0); drive(1, 1'b0, t0);
                tick();
                reset = 1'b0;
            end else begin
                tick();
                if (exp_ack[0]) drive(0, 1'($urandom % 2), rand_txn());
                else if (!p0_if.req && ($urandom % 3 == 0)) drive(0, 1'b1, rand_txn());
                if (exp_ack[1]) drive(1, 1'($urandom % 2), rand_txn());
                else if (!p1_if.req && ($urandom % 3 == 0)) drive(1, 1'b1, rand_txn());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
